eeprom_req_ctrl: RTL



---
 rtl/eeprom_req_if.sv | 23 ++
 rtl/eeprom_req_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/eeprom_req_if.sv
// Host-side request/response handshake bundle for eeprom_req_ctrl.
// The master modport is the host and the slave modport is the controller.
interface eeprom_req_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_wr;
   logic [10:0] req_addr;
   logic [7:0]  req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [7:0]  rsp_rdata;
   logic        rsp_err;

   modport master (
      output req_valid, req_wr, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_wr, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/eeprom_req_ctrl.sv
// Sequences single-byte host requests onto the EEPROM engine's WR/RD/ADDR/DATA/ACK handshake.
// Define EEPROM_VERIFY_EN to read back every write and flag a mismatch through rsp_err.
module eeprom_req_ctrl #(
   parameter int TIMEOUT_CYC = 4096,
   parameter int GAP_CYC     = 2
) (
   input  logic        CLK,
   input  logic        RESET,
   eeprom_req_if.slave host,
   output logic        WR,
   output logic        RD,
   output logic [10:0] ADDR,
   inout  wire  [7:0]  DATA,
   input  logic        ACK
);
   typedef enum logic [2:0] {
      S_IDLE, S_ISSUE, S_WAIT_ACK, S_RESP, S_GAP
`ifdef EEPROM_VERIFY_EN
      , S_VGAP, S_VISSUE, S_VWAIT
`endif
   } state_t;

   localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYC - 1);
   localparam logic [3:0]  GAP_LOAD = 4'(GAP_CYC);

   state_t      state_reg;
   logic        wr_reg;
   logic [7:0]  wdata_reg;
   logic        data_oe_reg;
   logic        req_ready_reg;
   logic        rsp_valid_reg;
   logic [7:0]  rsp_rdata_reg;
   logic        rsp_err_reg;
   logic [15:0] to_cnt_reg;
   logic [3:0]  gap_cnt_reg;
   logic [15:0] to_cnt_next;

   // Saturating so a stuck counter can never wrap back below the limit.
   assign to_cnt_next = (to_cnt_reg == 16'hFFFF) ? to_cnt_reg : to_cnt_reg + 16'd1;

   assign DATA           = data_oe_reg ? wdata_reg : 8'bz;
   assign host.req_ready = req_ready_reg;
   assign host.rsp_valid = rsp_valid_reg;
   assign host.rsp_rdata = rsp_rdata_reg;
   assign host.rsp_err   = rsp_err_reg;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_reg     <= S_GAP;
         gap_cnt_reg   <= GAP_LOAD;
         to_cnt_reg    <= 16'd0;
         wr_reg        <= 1'b0;
         wdata_reg     <= 8'h00;
         data_oe_reg   <= 1'b0;
         req_ready_reg <= 1'b0;
         rsp_valid_reg <= 1'b0;
         rsp_rdata_reg <= 8'h00;
         rsp_err_reg   <= 1'b0;
         WR            <= 1'b0;
         RD            <= 1'b0;
         ADDR          <= 11'd0;
      end else begin
         WR <= 1'b0;
         RD <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               if (host.req_valid) begin
                  req_ready_reg <= 1'b0;
                  wr_reg        <= host.req_wr;
                  ADDR          <= host.req_addr;
                  wdata_reg     <= host.req_wdata;
                  data_oe_reg   <= host.req_wr;
                  WR            <= host.req_wr;
                  RD            <= ~host.req_wr;
                  state_reg     <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               to_cnt_reg <= 16'd0;
               state_reg  <= S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
               // ACK is checked first so it wins over a timeout in the same cycle.
               if (ACK) begin
                  data_oe_reg   <= 1'b0;
                  rsp_err_reg   <= 1'b0;
                  rsp_rdata_reg <= wr_reg ? 8'h00 : DATA;
`ifdef EEPROM_VERIFY_EN
                  if (wr_reg) begin
                     if (GAP_CYC == 0) begin
                        RD        <= 1'b1;
                        state_reg <= S_VISSUE;
                     end else begin
                        gap_cnt_reg <= GAP_LOAD;
                        state_reg   <= S_VGAP;
                     end
                  end else begin
                     rsp_valid_reg <= 1'b1;
                     state_reg     <= S_RESP;
                  end
`else
                  rsp_valid_reg <= 1'b1;
                  state_reg     <= S_RESP;
`endif
               end else if (to_cnt_reg >= TO_LAST) begin
                  data_oe_reg   <= 1'b0;
                  rsp_err_reg   <= 1'b1;
                  rsp_rdata_reg <= 8'h00;
                  rsp_valid_reg <= 1'b1;
                  state_reg     <= S_RESP;
               end else begin
                  to_cnt_reg <= to_cnt_next;
               end
            end
`ifdef EEPROM_VERIFY_EN
            S_VGAP: begin
               if (gap_cnt_reg <= 4'd1) begin
                  RD        <= 1'b1;
                  state_reg <= S_VISSUE;
               end else begin
                  gap_cnt_reg <= gap_cnt_reg - 4'd1;
               end
            end
            S_VISSUE: begin
               to_cnt_reg <= 16'd0;
               state_reg  <= S_VWAIT;
            end
            S_VWAIT: begin
               if (ACK) begin
                  rsp_rdata_reg <= DATA;
                  rsp_err_reg   <= (DATA != wdata_reg);
                  rsp_valid_reg <= 1'b1;
                  state_reg     <= S_RESP;
               end else if (to_cnt_reg >= TO_LAST) begin
                  rsp_err_reg   <= 1'b1;
                  rsp_rdata_reg <= 8'h00;
                  rsp_valid_reg <= 1'b1;
                  state_reg     <= S_RESP;
               end else begin
                  to_cnt_reg <= to_cnt_next;
               end
            end
`endif
            S_RESP: begin
               if (host.rsp_ready) begin
                  rsp_valid_reg <= 1'b0;
                  if (GAP_CYC == 0) begin
                     req_ready_reg <= 1'b1;
                     state_reg     <= S_IDLE;
                  end else begin
                     gap_cnt_reg <= GAP_LOAD;
                     state_reg   <= S_GAP;
                  end
               end
            end
            S_GAP: begin
               if (gap_cnt_reg <= 4'd1) begin
                  req_ready_reg <= 1'b1;
                  state_reg     <= S_IDLE;
               end else begin
                  gap_cnt_reg <= gap_cnt_reg - 4'd1;
               end
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end
endmodule
